// File: rtl/div_seq_if.sv
// Purpose : request/response bundle between the EX stage and the sequential divider.
// Latency : none (wires only); timing is set by div_seq.
// Backpr. : EX holds start_i (and stalls) until ready_o; dropping start_i withdraws the request.
// Signals : signed_div_i, opdata1_i, opdata2_i, start_i, annul_i  (EX -> divider)
//           result_o {remainder, quotient}, ready_o                (divider -> EX)
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    // EX side
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_seq.sv
// Purpose : radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient} for HI/LO.
// Latency : ready_o after E(WIDTH+1) from the start edge E0; divide-by-zero after E2;
//           with DIV_EARLY_OUT_EN defined, |dividend| < |divisor| finishes after E1.
// Backpr. : result is held while start_i stays high in END; start_i low or annul_i aborts to FREE.
// Ports   : clk, Rst_n (async, active-high), bus (div_seq_if.slave).
// Config  : DIV_EARLY_OUT_EN enables the small-dividend early exit.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      Rst_n,
    div_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] quo_q;    // holds |dividend| at start; quotient bits shift in at the LSB
    logic [WIDTH-1:0] rem_q;    // partial remainder
    logic             sgn_q, a_neg_q, b_neg_q;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             req, div_zero, early_out, last_iter, abort;

    assign req      = bus.start_i && !bus.annul_i;
    assign abort    = bus.annul_i || !bus.start_i;
    assign div_zero = (bus.opdata2_i == '0);

    // Magnitudes: negate only for signed requests with the sign bit set.
    // -0x80000000 stays 0x80000000, which is the correct unsigned magnitude.
    assign a_mag = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign b_mag = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (a_mag < b_mag);
`else
    assign early_out = 1'b0;
`endif

    // Partial remainder is always < divisor, so the WIDTH+1-bit trial never
    // overflows and its MSB is a true sign bit.
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvsr_q};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    assign quo_fix = (sgn_q && (a_neg_q ^ b_neg_q)) ? -quo_q : quo_q;
    assign rem_fix = (sgn_q && a_neg_q) ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge Rst_n) begin
        if (Rst_n) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FREE: begin
                if (req) begin
                    if (div_zero) begin
                        state_d = ST_BYZERO;
                    end else if (early_out) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_BYZERO: begin
                state_d = bus.annul_i ? ST_FREE : ST_END;
            end
            ST_ON: begin
                if (abort) begin
                    state_d = ST_FREE;
                end else if (last_iter) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                // start_i held here never restarts; FREE must be visited first
                if (abort) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst_n) begin
        if (Rst_n) begin
            cnt_q        <= '0;
            dvsr_q       <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            sgn_q        <= 1'b0;
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            bus.ready_o  <= 1'b0;
            bus.result_o <= '0;
        end else begin
            // Outputs are only non-zero while sitting in END
            bus.ready_o  <= 1'b0;
            bus.result_o <= '0;
            case (state_q)
                ST_FREE: begin
                    if (req) begin
                        dvsr_q  <= b_mag;
                        sgn_q   <= bus.signed_div_i;
                        a_neg_q <= bus.signed_div_i && bus.opdata1_i[WIDTH-1];
                        b_neg_q <= bus.signed_div_i && bus.opdata2_i[WIDTH-1];
                        cnt_q   <= '0;
                        if (early_out) begin
                            quo_q <= '0;
                            rem_q <= a_mag;
                        end else begin
                            quo_q <= a_mag;
                            rem_q <= '0;
                        end
                    end
                end
                ST_BYZERO: begin
                    quo_q <= '0;
                    rem_q <= '0;
                end
                ST_ON: begin
                    if (!abort) begin
                        rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_END: begin
                    if (!abort) begin
                        bus.ready_o  <= 1'b1;
                        bus.result_o <= {rem_fix, quo_fix};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
